// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and fetch-stage state encoding.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FETCH,
      SQUASH,
      HALTED
   } fetch_state_t;

   localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry skid register holding a fetched {instr, pc4} while decode stalls.
module fetch_buffer
   import cpu_types_pkg::*;
(
   input  logic  clk_i,
   input  logic  rst_i,
   input  logic  load_i,
   input  logic  drain_i,
   input  logic  clear_i,
   input  word_t instr_i,
   input  word_t pc4_i,
   output logic  valid_o,
   output word_t instr_o,
   output word_t pc4_o
);

   logic  valid_q;
   word_t instr_q;
   word_t pc4_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         instr_q <= '0;
         pc4_q   <= '0;
      end else if (clear_i || drain_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         instr_q <= instr_i;
         pc4_q   <= pc4_i;
      end
   end

   assign valid_o = valid_q;
   assign instr_o = instr_q;
   assign pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, icache request, redirect/halt handling.
module fetch_unit
   import cpu_types_pkg::*;
#(
   parameter word_t PC_INIT = 32'h0000_0000
) (
   input  logic  CLK,
   input  logic  RST,
   input  logic  ihit,
   input  word_t iload,
   output logic  imemREN,
   output word_t imemaddr,
   input  logic  pc_stall,
   input  logic  redirect_valid,
   input  word_t redirect_pc,
   input  logic  halt_req,
   output word_t instr_fet,
   output word_t pc4_fet,
   output logic  fet_valid,
   output logic  halted
);

   fetch_state_t state_q;
   word_t        pc_q;
   word_t        pend_pc_q;
   logic         pend_halt_q;

   word_t        pend_pc_d;
   logic         pend_halt_d;
   word_t        pc_inc;
   logic         in_fetch;
   logic         miss;
   logic         take;

   logic         buf_valid;
   word_t        buf_instr;
   word_t        buf_pc4;
   logic         buf_load;
   logic         buf_drain;
   logic         buf_clear;

   assign pc_inc   = pc_q + PC_STEP;
   assign in_fetch = (state_q == FETCH);
   assign imemREN  = (state_q != HALTED) && !buf_valid;
   assign imemaddr = pc_q;
   assign miss     = imemREN && !ihit;
   assign take     = ihit && imemREN;
   assign halted   = (state_q == HALTED);

   assign fet_valid = !redirect_valid &&
                      (buf_valid || (in_fetch && take));
   assign instr_fet = buf_valid ? buf_instr : iload;
   assign pc4_fet   = buf_valid ? buf_pc4 : pc_inc;

   // A redirect in SQUASH replaces the target and cancels any pending halt.
   assign pend_pc_d   = redirect_valid ? redirect_pc : pend_pc_q;
   assign pend_halt_d = !redirect_valid && (pend_halt_q || halt_req);

   assign buf_clear = in_fetch && (redirect_valid || halt_req);
   assign buf_drain = in_fetch && buf_valid && !pc_stall;
   assign buf_load  = in_fetch && take && pc_stall;

   fetch_buffer u_buf (
      .clk_i   (CLK),
      .rst_i   (RST),
      .load_i  (buf_load),
      .drain_i (buf_drain),
      .clear_i (buf_clear),
      .instr_i (iload),
      .pc4_i   (pc_inc),
      .valid_o (buf_valid),
      .instr_o (buf_instr),
      .pc4_o   (buf_pc4)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= FETCH;
         pc_q        <= PC_INIT;
         pend_pc_q   <= '0;
         pend_halt_q <= 1'b0;
      end else begin
         case (state_q)
            FETCH: begin
               if (redirect_valid) begin
                  if (miss) begin
                     pend_pc_q <= redirect_pc;
                     state_q   <= SQUASH;
                  end else begin
                     pc_q <= redirect_pc;
                  end
               end else if (halt_req) begin
                  if (miss) begin
                     pend_halt_q <= 1'b1;
                     state_q     <= SQUASH;
                  end else begin
                     state_q <= HALTED;
                  end
               end else if (take) begin
                  pc_q <= pc_inc;
               end
            end
            SQUASH: begin
               if (ihit) begin
                  pend_halt_q <= 1'b0;
                  if (pend_halt_d) begin
                     state_q <= HALTED;
                  end else begin
                     pc_q    <= pend_pc_d;
                     state_q <= FETCH;
                  end
               end else begin
                  pend_pc_q   <= pend_pc_d;
                  pend_halt_q <= pend_halt_d;
               end
            end
            default: begin
               state_q <= HALTED;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: reference model plus directed and random stimulus.
module tb_fetch_unit;
   import cpu_types_pkg::*;

   logic  CLK;
   logic  RST;
   logic  ihit;
   word_t iload;
   logic  imemREN;
   word_t imemaddr;
   logic  pc_stall;
   logic  redirect_valid;
   word_t redirect_pc;
   logic  halt_req;
   word_t instr_fet;
   word_t pc4_fet;
   logic  fet_valid;
   logic  halted;

   fetch_unit #(.PC_INIT(32'h0)) dut (
      .CLK            (CLK),
      .RST            (RST),
      .ihit           (ihit),
      .iload          (iload),
      .imemREN        (imemREN),
      .imemaddr       (imemaddr),
      .pc_stall       (pc_stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req),
      .instr_fet      (instr_fet),
      .pc4_fet        (pc4_fet),
      .fet_valid      (fet_valid),
      .halted         (halted)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      bit    ren;
      word_t addr;
      bit    fv;
      word_t instr;
      word_t pc4;
      bit    hlt;
   } exp_t;

   typedef struct {
      word_t instr;
      word_t pc4;
   } item_t;

   exp_t  sb[$];
   item_t hold[$];

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   word_t m_pc;
   word_t m_tgt;
   bit    m_stop;
   bit    m_disc;
   bit    m_hp;

   task automatic chk(input string n, input word_t a,
                      input word_t e);
      n_checks++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   task automatic model_reset();
      m_pc   = 32'h0;
      m_tgt  = 32'h0;
      m_stop = 1'b0;
      m_disc = 1'b0;
      m_hp   = 1'b0;
      hold.delete();
   endtask

   task automatic idle();
      ihit           = 1'b0;
      iload          = 32'h0;
      pc_stall       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      halt_req       = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      #1;
      RST = 1'b1;
      idle();
      #1;
      chk("rst_addr", imemaddr, 32'h0);
      chk("rst_ren", {31'b0, imemREN}, 32'h1);
      chk("rst_fv", {31'b0, fet_valid}, 32'h0);
      chk("rst_halted", {31'b0, halted}, 32'h0);
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   task automatic cyc(input bit h, input word_t ld, input bit st,
                      input bit rv, input word_t rp, input bit hr);
      exp_t  e;
      item_t it;
      bit    ren;
      @(posedge CLK);
      #1;
      ihit           = h;
      iload          = ld;
      pc_stall       = st;
      redirect_valid = rv;
      redirect_pc    = rp;
      halt_req       = hr;
      ren    = !m_stop && (hold.size() == 0);
      e.ren  = ren;
      e.addr = m_pc;
      e.hlt  = m_stop;
      e.fv   = !rv && (hold.size() != 0 ||
                       (!m_stop && !m_disc && h && ren));
      if (hold.size() != 0) begin
         e.instr = hold[0].instr;
         e.pc4   = hold[0].pc4;
      end else begin
         e.instr = ld;
         e.pc4   = m_pc + 32'd4;
      end
      sb.push_back(e);
      if (m_stop) begin
      end else if (m_disc) begin
         if (rv) begin
            m_tgt = rp;
            m_hp  = 1'b0;
         end else if (hr) begin
            m_hp = 1'b1;
         end
         if (h) begin
            if (m_hp) m_stop = 1'b1;
            else m_pc = m_tgt;
            m_disc = 1'b0;
            m_hp   = 1'b0;
         end
      end else if (rv) begin
         hold.delete();
         if (ren && !h) begin
            m_tgt  = rp;
            m_disc = 1'b1;
         end else begin
            m_pc = rp;
         end
      end else if (hr) begin
         hold.delete();
         if (ren && !h) begin
            m_hp   = 1'b1;
            m_disc = 1'b1;
         end else begin
            m_stop = 1'b1;
         end
      end else if (hold.size() != 0) begin
         if (!st) hold.delete();
      end else if (h && ren) begin
         if (st) begin
            it.instr = ld;
            it.pc4   = m_pc + 32'd4;
            hold.push_back(it);
         end
         m_pc = m_pc + 32'd4;
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge CLK);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("imemREN", {31'b0, imemREN}, {31'b0, e.ren});
            chk("imemaddr", imemaddr, e.addr);
            chk("fet_valid", {31'b0, fet_valid}, {31'b0, e.fv});
            chk("halted", {31'b0, halted}, {31'b0, e.hlt});
            if (e.fv) begin
               chk("instr_fet", instr_fet, e.instr);
               chk("pc4_fet", pc4_fet, e.pc4);
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      RST = 1'b1;
      idle();
      model_reset();
      do_reset();

      // T1
      cyc(1, 32'h2001000A, 0, 0, 0, 0);
      #2;
      chk("t1_instr", instr_fet, 32'h2001000A);
      chk("t1_pc4", pc4_fet, 32'h4);
      chk("t1_fv", {31'b0, fet_valid}, 32'h1);
      cyc(0, 0, 0, 0, 0, 0);
      #2 chk("t1_next", imemaddr, 32'h4);

      // T2
      cyc(1, 32'h11, 0, 0, 0, 0);
      cyc(1, 32'hAC220000, 1, 0, 0, 0);
      cyc(1, 32'h22, 1, 0, 0, 0);
      #2;
      chk("t2_ren", {31'b0, imemREN}, 32'h0);
      chk("t2_addr", imemaddr, 32'hC);
      chk("t2_fv", {31'b0, fet_valid}, 32'h1);
      chk("t2_instr", instr_fet, 32'hAC220000);
      cyc(0, 0, 0, 0, 0, 0);
      #2 chk("t2_pc4", pc4_fet, 32'hC);
      cyc(0, 0, 0, 0, 0, 0);
      #2 chk("t2_ren1", {31'b0, imemREN}, 32'h1);

      // T3
      cyc(1, 32'h33, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 32'h40, 0);
      cyc(0, 0, 0, 0, 0, 0);
      #2 chk("t3_hold", imemaddr, 32'h10);
      cyc(1, 32'h44, 0, 0, 0, 0);
      #2 chk("t3_fv", {31'b0, fet_valid}, 32'h0);
      cyc(0, 0, 0, 0, 0, 0);
      #2 chk("t3_addr", imemaddr, 32'h40);

      // T4
      cyc(1, 32'h55, 0, 1, 32'h80, 1);
      cyc(0, 0, 0, 0, 0, 0);
      #2;
      chk("t4_halted", {31'b0, halted}, 32'h0);
      chk("t4_addr", imemaddr, 32'h80);

      // PC wrap
      cyc(1, 32'h66, 0, 1, 32'hFFFF_FFFC, 0);
      cyc(1, 32'h77, 0, 0, 0, 0);
      #2 chk("wrap_pc4", pc4_fet, 32'h0);
      cyc(0, 0, 0, 0, 0, 0);
      #2 chk("wrap_addr", imemaddr, 32'h0);

      // T5
      cyc(1, 32'h88, 0, 1, 32'h20, 0);
      cyc(1, 32'h99, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0);
      #2;
      chk("t5_halted", {31'b0, halted}, 32'h1);
      chk("t5_ren", {31'b0, imemREN}, 32'h0);
      cyc(1, 0, 0, 1, 32'h100, 0);
      cyc(0, 0, 0, 0, 0, 0);
      #2;
      chk("t5_addr", imemaddr, 32'h20);
      chk("t5_halted2", {31'b0, halted}, 32'h1);

      // T6: reset from SQUASH, then from a full buffer
      do_reset();
      cyc(1, 32'hAA, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 32'h30, 0);
      do_reset();
      cyc(1, 32'hBB, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      do_reset();

      // random episodes
      for (int ep = 0; ep < 8; ep++) begin
         for (int c = 0; c < 300; c++) begin
            word_t rp;
            rp = $urandom & 32'h0000_00FC;
            if ($urandom_range(0, 7) == 0)
               rp = 32'hFFFF_FFF8;
            cyc($urandom_range(0, 9) < 6, $urandom,
                $urandom_range(0, 9) < 3,
                $urandom_range(0, 14) == 0, rp,
                $urandom_range(0, 79) == 0);
         end
         do_reset();
      end

      @(negedge CLK);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
